// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit placed after the register file.
//   A request carries funct3, both operands and a destination register. The
//   unit runs one shift/add (multiply) or shift/subtract (divide) step per
//   clock and presents a result/address pair for the register file write port.
//
// Parameters
//   XLEN        operand/result width; an operation takes XLEN iterations
//   REG_ADDR_W  destination register address width
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous abort of any in-flight operation
//   start_valid   request valid
//   start_ready   request accepted when high (unit idle)
//   funct3        000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_data      operand A (multiplicand / dividend)
//   rs2_data      operand B (multiplier / divisor)
//   rd_addr       destination register of the request
//   result_valid  result available, held stable until accepted
//   result_ready  consumer accepts the result
//   result_data   result value
//   result_addr   destination register of the result
//   busy          unit is not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high and flush is low. Valid never waits for ready, and everything
//   offered with valid stays stable until the transfer edge.
//
// Build option
//   MULDIV_EARLY_OUT_EN  divide-by-zero, signed overflow and multiplies with
//                        a zero operand skip the iterations and present their
//                        result one edge after acceptance. When undefined,
//                        every operation has the fixed XLEN+1 latency.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [XLEN-1:0]       result_data,
    output logic [REG_ADDR_W-1:0] result_addr,
    output logic                  busy
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        count_q;
    logic [XLEN-1:0]         acc_q;      // product high half / partial remainder
    logic [XLEN-1:0]         lo_q;       // product low half / dividend -> quotient
    logic [XLEN-1:0]         b_q;        // multiplicand / divisor magnitude
    logic                    mul_lo_q;   // MUL: return low half of the product
    logic                    div_q;      // divide family
    logic                    rem_q;      // REM/REMU when div_q
    logic                    neg_q;      // product / quotient must be negated
    logic                    a_neg_q;    // signed dividend was negative
    logic                    b_zero_q;   // divisor was zero
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    result_valid_q;
    logic [XLEN-1:0]         result_data_q;
    logic [REG_ADDR_W-1:0]   result_addr_q;

    assign start_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_addr  = result_addr_q;

    // ------------------------------------------------------------------------
    // Request decode: operand signedness and magnitudes
    // ------------------------------------------------------------------------
    logic                  is_div_d;
    logic                  a_signed_d;
    logic                  b_signed_d;
    logic                  a_neg_d;
    logic                  b_neg_d;
    logic [XLEN-1:0]       a_mag_d;
    logic [XLEN-1:0]       b_mag_d;
    logic [XLEN-1:0]       acc_init_d;
    logic [XLEN-1:0]       lo_init_d;
    logic [CNT_W-1:0]      count_init_d;

    always_comb begin
        is_div_d     = funct3[2];
        a_signed_d   = is_div_d ? ~funct3[0]
                                : (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        b_signed_d   = is_div_d ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg_d      = a_signed_d & rs1_data[XLEN-1];
        b_neg_d      = b_signed_d & rs2_data[XLEN-1];
        a_mag_d      = a_neg_d ? -rs1_data : rs1_data;
        b_mag_d      = b_neg_d ? -rs2_data : rs2_data;
        acc_init_d   = '0;
        lo_init_d    = a_mag_d;
        count_init_d = CNT_W'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
        // Special cases start with zero iterations left; the single finishing
        // edge then produces the result from suitably preloaded registers:
        // zero product for multiplies, remainder = |rs1| for divide-by-zero,
        // and for signed overflow the untouched |rs1| already reads back as
        // quotient = most-negative, remainder = 0.
        if (is_div_d) begin
            if (rs2_data == '0) begin
                count_init_d = '0;
                acc_init_d   = a_mag_d;
            end else if (~funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2_data == '1)) begin
                count_init_d = '0;
            end
        end else if ((rs1_data == '0) || (rs2_data == '0)) begin
            count_init_d = '0;
            lo_init_d    = '0;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]   mul_add;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   acc_step_d;
    logic [XLEN-1:0]   lo_step_d;

    always_comb begin
        mul_add    = lo_q[0] ? b_q : {XLEN{1'b0}};
        mul_sum    = {1'b0, acc_q} + {1'b0, mul_add};
        div_shift  = {acc_q, lo_q[XLEN-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, b_q};
        acc_step_d = acc_q;
        lo_step_d  = lo_q;
        if (div_q) begin
            // Restoring division: keep the subtraction only when it did not
            // borrow. The partial remainder stays below the divisor, so it
            // always fits in XLEN bits.
            if (!div_diff[XLEN+1]) begin
                acc_step_d = div_diff[XLEN-1:0];
                lo_step_d  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step_d = div_shift[XLEN-1:0];
                lo_step_d  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply: {acc, lo} shifts right with the carry-out.
            acc_step_d = mul_sum[XLEN:1];
            lo_step_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Sign fix-up and result selection (used on the finishing edge)
    // ------------------------------------------------------------------------
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_d;

    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quot_fix = neg_q ? -lo_q : lo_q;
        // Divide-by-zero leaves |rs1| as the remainder, so the dividend sign
        // fix-up returns rs1 itself.
        rem_fix  = a_neg_q ? -acc_q : acc_q;
        if (!div_q) begin
            result_d = mul_lo_q ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (rem_q) begin
            result_d = rem_fix;
        end else begin
            result_d = b_zero_q ? {XLEN{1'b1}} : quot_fix;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            acc_q          <= '0;
            lo_q           <= '0;
            b_q            <= '0;
            mul_lo_q       <= 1'b0;
            div_q          <= 1'b0;
            rem_q          <= 1'b0;
            neg_q          <= 1'b0;
            a_neg_q        <= 1'b0;
            b_zero_q       <= 1'b0;
            rd_q           <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_addr_q  <= '0;
        end else if (flush) begin
            // Abort wins over acceptance and over a pending result transfer;
            // the last presented data/address are left as they were.
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        acc_q    <= acc_init_d;
                        lo_q     <= lo_init_d;
                        b_q      <= b_mag_d;
                        count_q  <= count_init_d;
                        mul_lo_q <= (funct3 == 3'b000);
                        div_q    <= is_div_d;
                        rem_q    <= funct3[1];
                        neg_q    <= a_neg_d ^ b_neg_d;
                        a_neg_q  <= a_neg_d;
                        b_zero_q <= (rs2_data == '0);
                        rd_q     <= rd_addr;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (count_q != '0) begin
                        acc_q   <= acc_step_d;
                        lo_q    <= lo_step_d;
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        result_data_q  <= result_d;
                        result_addr_q  <= rd_q;
                        result_valid_q <= 1'b1;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    result_valid_q <= 1'b0;
                    state_q        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
